// File: rtl/tlb_unit.sv
// 16-entry joint TLB: two combinational lookup ports plus a TLBP/TLBR/TLBWI engine for CP0.
// Lookups have zero latency; an op accepted at cycle N pulses its result and op_done at N+1.
// op_ready drops for the single RESP cycle, so back-to-back requests are accepted every other cycle.
module tlb_unit #(
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic [18:0] s0_vpn2,
    input  logic        s0_odd_page,
    input  logic [7:0]  s0_asid,
    output logic        s0_found,
    output logic [3:0]  s0_index,
    output logic [19:0] s0_pfn,
    output logic [2:0]  s0_c,
    output logic        s0_d,
    output logic        s0_v,

    input  logic [18:0] s1_vpn2,
    input  logic        s1_odd_page,
    input  logic [7:0]  s1_asid,
    output logic        s1_found,
    output logic [3:0]  s1_index,
    output logic [19:0] s1_pfn,
    output logic [2:0]  s1_c,
    output logic        s1_d,
    output logic        s1_v,

    input  logic        op_valid,
    input  logic [1:0]  op_code,
    output logic        op_ready,

    input  logic [31:0] c0_entryhi,
    input  logic [31:0] c0_entrylo0,
    input  logic [31:0] c0_entrylo1,
    input  logic [31:0] c0_index,

    output logic        tlbp_op,
    output logic        p_found,
    output logic [3:0]  p_index,

    output logic        tlbr_op,
    output logic [18:0] r_vpn2,
    output logic [7:0]  r_asid,
    output logic        r_g,
    output logic [19:0] r_pfn0,
    output logic [2:0]  r_c0,
    output logic        r_d0,
    output logic        r_v0,
    output logic [19:0] r_pfn1,
    output logic [2:0]  r_c1,
    output logic        r_d1,
    output logic        r_v1,

    output logic        op_done
);

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    typedef enum logic {IDLE, RESP} state_t;

    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBR  = 2'b10;
    localparam logic [1:0] OP_TLBWI = 2'b11;

    tlb_entry_t  entry_q [TLBNUM];
    tlb_entry_t  rd_q;
    tlb_entry_t  wr_entry;
    tlb_entry_t  s0_sel;
    tlb_entry_t  s1_sel;
    state_t      state_q;
    state_t      state_d;
    logic [1:0]  op_q;
    logic        accept;
    logic [15:0] s0_hit;
    logic [15:0] s1_hit;
    logic [15:0] probe_hit;
    logic        unused_bits;

    // Priority encoder: lowest set bit wins, 0 when nothing hits.
    function automatic logic [3:0] lowest_hit(input logic [15:0] hit);
        logic [3:0] idx;
        idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    always_comb begin
        s0_hit    = '0;
        s1_hit    = '0;
        probe_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            s0_hit[i]    = (entry_q[i].vpn2 == s0_vpn2) &&
                           (entry_q[i].g || entry_q[i].asid == s0_asid);
            s1_hit[i]    = (entry_q[i].vpn2 == s1_vpn2) &&
                           (entry_q[i].g || entry_q[i].asid == s1_asid);
            probe_hit[i] = (entry_q[i].vpn2 == c0_entryhi[31:13]) &&
                           (entry_q[i].g || entry_q[i].asid == c0_entryhi[7:0]);
        end
    end

    assign s0_found = |s0_hit;
    assign s1_found = |s1_hit;
    assign s0_index = lowest_hit(s0_hit);
    assign s1_index = lowest_hit(s1_hit);
    assign s0_sel   = entry_q[s0_index];
    assign s1_sel   = entry_q[s1_index];

    // A miss still selects entry 0, so the page fields must be gated by found.
    always_comb begin
        {s0_pfn, s0_c, s0_d, s0_v} = '0;
        {s1_pfn, s1_c, s1_d, s1_v} = '0;
        if (s0_found) begin
            {s0_pfn, s0_c, s0_d, s0_v} = s0_odd_page ? {s0_sel.pfn1, s0_sel.c1, s0_sel.d1, s0_sel.v1}
                                                     : {s0_sel.pfn0, s0_sel.c0, s0_sel.d0, s0_sel.v0};
        end
        if (s1_found) begin
            {s1_pfn, s1_c, s1_d, s1_v} = s1_odd_page ? {s1_sel.pfn1, s1_sel.c1, s1_sel.d1, s1_sel.v1}
                                                     : {s1_sel.pfn0, s1_sel.c0, s1_sel.d0, s1_sel.v0};
        end
    end

    always_comb begin
        wr_entry      = '0;
        wr_entry.vpn2 = c0_entryhi[31:13];
        wr_entry.asid = c0_entryhi[7:0];
        wr_entry.g    = c0_entrylo0[0] & c0_entrylo1[0];
        wr_entry.pfn0 = c0_entrylo0[25:6];
        wr_entry.c0   = c0_entrylo0[5:3];
        wr_entry.d0   = c0_entrylo0[2];
        wr_entry.v0   = c0_entrylo0[1];
        wr_entry.pfn1 = c0_entrylo1[25:6];
        wr_entry.c1   = c0_entrylo1[5:3];
        wr_entry.d1   = c0_entrylo1[2];
        wr_entry.v1   = c0_entrylo1[1];
    end

    assign unused_bits = ^{c0_entryhi[12:8], c0_entrylo0[31:26], c0_entrylo1[31:26], c0_index[31:4]};

    assign accept = (state_q == IDLE) && op_valid && (op_code != 2'b00);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        op_ready = 1'b0;
        op_done  = 1'b0;
        tlbp_op  = 1'b0;
        tlbr_op  = 1'b0;
        case (state_q)
            IDLE: op_ready = 1'b1;
            RESP: begin
                op_done = 1'b1;
                tlbp_op = (op_q == OP_TLBP);
                tlbr_op = (op_q == OP_TLBR);
            end
            default: ;
        endcase
    end

    // Probe and write both act at the accept edge, so a TLBP right after a TLBWI sees the new entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) entry_q[i] <= '0;
            rd_q      <= '0;
            op_q      <= 2'b00;
            p_found   <= 1'b0;
            p_index   <= '0;
        end else if (accept) begin
            op_q <= op_code;
            case (op_code)
                OP_TLBP: begin
                    p_found <= |probe_hit;
                    p_index <= lowest_hit(probe_hit);
                end
                OP_TLBR:  rd_q <= entry_q[c0_index[3:0]];
                OP_TLBWI: entry_q[c0_index[3:0]] <= wr_entry;
                default: ;
            endcase
        end
    end

    assign r_vpn2 = rd_q.vpn2;
    assign r_asid = rd_q.asid;
    assign r_g    = rd_q.g;
    assign r_pfn0 = rd_q.pfn0;
    assign r_c0   = rd_q.c0;
    assign r_d0   = rd_q.d0;
    assign r_v0   = rd_q.v0;
    assign r_pfn1 = rd_q.pfn1;
    assign r_c1   = rd_q.c1;
    assign r_d1   = rd_q.d1;
    assign r_v1   = rd_q.v1;

endmodule

// File: tb/tb_tlb_unit.sv
// Bench for tlb_unit: directed vector tables, multi-cycle corner sequences and a randomized run
// checked against an array-based model of the TLB.
module tb_tlb_unit;

    logic        clk;
    logic        resetn;
    logic [18:0] s0_vpn2, s1_vpn2;
    logic        s0_odd_page, s1_odd_page;
    logic [7:0]  s0_asid, s1_asid;
    logic        s0_found, s1_found;
    logic [3:0]  s0_index, s1_index;
    logic [19:0] s0_pfn, s1_pfn;
    logic [2:0]  s0_c, s1_c;
    logic        s0_d, s1_d, s0_v, s1_v;
    logic        op_valid;
    logic [1:0]  op_code;
    logic        op_ready;
    logic [31:0] c0_entryhi, c0_entrylo0, c0_entrylo1, c0_index;
    logic        tlbp_op, p_found;
    logic [3:0]  p_index;
    logic        tlbr_op;
    logic [18:0] r_vpn2;
    logic [7:0]  r_asid;
    logic        r_g;
    logic [19:0] r_pfn0, r_pfn1;
    logic [2:0]  r_c0, r_c1;
    logic        r_d0, r_v0, r_d1, r_v1;
    logic        op_done;

    tlb_unit dut (
        .clk(clk), .resetn(resetn),
        .s0_vpn2(s0_vpn2), .s0_odd_page(s0_odd_page), .s0_asid(s0_asid),
        .s0_found(s0_found), .s0_index(s0_index), .s0_pfn(s0_pfn),
        .s0_c(s0_c), .s0_d(s0_d), .s0_v(s0_v),
        .s1_vpn2(s1_vpn2), .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index), .s1_pfn(s1_pfn),
        .s1_c(s1_c), .s1_d(s1_d), .s1_v(s1_v),
        .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
        .c0_entryhi(c0_entryhi), .c0_entrylo0(c0_entrylo0),
        .c0_entrylo1(c0_entrylo1), .c0_index(c0_index),
        .tlbp_op(tlbp_op), .p_found(p_found), .p_index(p_index),
        .tlbr_op(tlbr_op), .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
        .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
        .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
        .op_done(op_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: raw CP0 register images per entry, decoded on demand.
    logic [18:0] m_vpn2 [16];
    logic [7:0]  m_asid [16];
    logic        m_g    [16];
    logic [31:0] m_lo0  [16];
    logic [31:0] m_lo1  [16];

    logic        e_pf;
    logic [3:0]  e_pi;
    logic [18:0] e_rvpn2;
    logic [7:0]  e_rasid;
    logic        e_rg;
    logic [31:0] e_rlo0, e_rlo1;

    typedef struct {
        int          port;
        logic [18:0] vpn2;
        logic        odd;
        logic [7:0]  asid;
        logic        found;
        logic [3:0]  index;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
    } look_vec_t;

    typedef struct {
        logic [31:0] hi;
        logic        found;
        logic [3:0]  index;
    } probe_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_vpn2[i] = '0; m_asid[i] = '0; m_g[i] = 1'b0; m_lo0[i] = '0; m_lo1[i] = '0;
        end
        e_pf = 1'b0; e_pi = '0; e_rvpn2 = '0; e_rasid = '0; e_rg = 1'b0; e_rlo0 = '0; e_rlo1 = '0;
    endtask

    task automatic mlook(input logic [18:0] vpn2, input logic [7:0] asid, output logic f, output int idx);
        f = 1'b0;
        idx = 0;
        for (int i = 0; i < 16; i++) begin
            if (!f && m_vpn2[i] == vpn2 && (m_g[i] || m_asid[i] == asid)) begin
                f = 1'b1;
                idx = i;
            end
        end
    endtask

    task automatic model_accept(input logic [1:0] code, input logic [3:0] idx,
                                input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        logic f;
        int   i;
        case (code)
            2'b01: begin
                mlook(hi[31:13], hi[7:0], f, i);
                e_pf = f;
                e_pi = f ? 4'(i) : 4'd0;
            end
            2'b10: begin
                e_rvpn2 = m_vpn2[idx]; e_rasid = m_asid[idx]; e_rg = m_g[idx];
                e_rlo0 = m_lo0[idx]; e_rlo1 = m_lo1[idx];
            end
            2'b11: begin
                m_vpn2[idx] = hi[31:13]; m_asid[idx] = hi[7:0];
                m_g[idx] = lo0[0] & lo1[0];
                m_lo0[idx] = lo0; m_lo1[idx] = lo1;
            end
            default: ;
        endcase
    endtask

    task automatic chk_results();
        chk("p_found", p_found, e_pf);
        chk("p_index", p_index, e_pi);
        chk("r_vpn2", r_vpn2, e_rvpn2);
        chk("r_asid", r_asid, e_rasid);
        chk("r_g", r_g, e_rg);
        chk("r_even", {r_pfn0, r_c0, r_d0, r_v0}, e_rlo0[25:1]);
        chk("r_odd", {r_pfn1, r_c1, r_d1, r_v1}, e_rlo1[25:1]);
    endtask

    task automatic do_op(input logic [1:0] code, input logic [3:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        int w = 0;
        while (!op_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        if (!op_ready) chk("op_ready_timeout", op_ready, 1);
        op_code = code; c0_index = {28'd0, idx};
        c0_entryhi = hi; c0_entrylo0 = lo0; c0_entrylo1 = lo1;
        op_valid = 1'b1;
        @(posedge clk);
        model_accept(code, idx, hi, lo0, lo1);
        #1 op_valid = 1'b0;
        chk("resp_op_done", op_done, 1);
        chk("resp_op_ready", op_ready, 0);
        chk("resp_tlbp_op", tlbp_op, code == 2'b01);
        chk("resp_tlbr_op", tlbr_op, code == 2'b10);
        chk_results();
        @(posedge clk); #1;
        chk("after_op_done", op_done, 0);
        chk("after_pulses", {tlbp_op, tlbr_op}, 0);
    endtask

    task automatic read_port(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                             output logic [31:0] f, output logic [31:0] idx, output logic [31:0] pg);
        @(negedge clk);
        if (port == 0) begin
            s0_vpn2 = vpn2; s0_odd_page = odd; s0_asid = asid;
        end else begin
            s1_vpn2 = vpn2; s1_odd_page = odd; s1_asid = asid;
        end
        #1;
        f   = (port == 0) ? 32'(s0_found) : 32'(s1_found);
        idx = (port == 0) ? 32'(s0_index) : 32'(s1_index);
        pg  = (port == 0) ? 32'({s0_pfn, s0_c, s0_d, s0_v}) : 32'({s1_pfn, s1_c, s1_d, s1_v});
    endtask

    task automatic chk_look(input int port, input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
        logic [31:0] af, ai, ap, lo;
        logic        f;
        int          i;
        read_port(port, vpn2, odd, asid, af, ai, ap);
        mlook(vpn2, asid, f, i);
        lo = !f ? 32'd0 : (odd ? m_lo1[i] : m_lo0[i]);
        chk(port == 0 ? "s0_found" : "s1_found", af, 32'(f));
        chk(port == 0 ? "s0_index" : "s1_index", ai, f ? i : 0);
        chk(port == 0 ? "s0_page" : "s1_page", ap, 32'(lo[25:1]));
    endtask

    look_vec_t  lv [9];
    probe_vec_t pv [4];
    logic [18:0] pool [5];

    initial begin
        logic [31:0] af, ai, ap;
        lv[0] = '{1, 19'h12345, 1'b1, 8'h05, 1'b1, 4'd3, 20'h81,  3'd1, 1'b1, 1'b1};
        lv[1] = '{0, 19'h12345, 1'b0, 8'h05, 1'b1, 4'd3, 20'h48,  3'd6, 1'b1, 1'b1};
        lv[2] = '{0, 19'h12345, 1'b1, 8'h06, 1'b0, 4'd0, 20'h0,   3'd0, 1'b0, 1'b0};
        lv[3] = '{0, 19'h00ABC, 1'b0, 8'h02, 1'b1, 4'd7, 20'h100, 3'd3, 1'b0, 1'b1};
        lv[4] = '{1, 19'h00ABC, 1'b1, 8'hFF, 1'b1, 4'd7, 20'h200, 3'd2, 1'b1, 1'b0};
        lv[5] = '{1, 19'h0F0F0, 1'b0, 8'h22, 1'b1, 4'd2, 20'h1,   3'd0, 1'b0, 1'b1};
        lv[6] = '{0, 19'h0F0F0, 1'b0, 8'h23, 1'b0, 4'd0, 20'h0,   3'd0, 1'b0, 1'b0};
        lv[7] = '{0, 19'h00000, 1'b1, 8'h00, 1'b1, 4'd0, 20'h0,   3'd0, 1'b0, 1'b0};
        lv[8] = '{1, 19'h7FFFF, 1'b0, 8'h05, 1'b0, 4'd0, 20'h0,   3'd0, 1'b0, 1'b0};
        pv[0] = '{32'h1E1E0022, 1'b1, 4'd2};
        pv[1] = '{32'hFFFFE001, 1'b0, 4'd0};
        pv[2] = '{32'h2468A005, 1'b1, 4'd3};
        pv[3] = '{32'h01578002, 1'b1, 4'd7};
        pool[0] = 19'h12345; pool[1] = 19'h00ABC; pool[2] = 19'h0F0F0; pool[3] = 19'h55555; pool[4] = 19'h0;

        resetn = 1'b0; op_valid = 1'b0; op_code = 2'b00;
        c0_entryhi = '0; c0_entrylo0 = '0; c0_entrylo1 = '0; c0_index = '0;
        s0_vpn2 = '0; s0_odd_page = 1'b0; s0_asid = '0;
        s1_vpn2 = '0; s1_odd_page = 1'b0; s1_asid = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;

        chk("rst_op_ready", op_ready, 1);
        chk("rst_pulses", {tlbp_op, tlbr_op, op_done}, 0);
        chk_results();
        read_port(0, 19'h12345, 1'b0, 8'h05, af, ai, ap);
        chk("rst_s0_found", af, 0);

        do_op(2'b11, 4'd3, 32'h2468A005, 32'h00001237, 32'h0000204E);
        do_op(2'b11, 4'd7, 32'h01578009, 32'h0000401B, 32'h00008015);
        do_op(2'b11, 4'd2, 32'h1E1E0022, 32'h00000042, 32'h00000000);
        do_op(2'b11, 4'd9, 32'h1E1E0022, 32'h00000142, 32'h00000000);

        for (int k = 0; k < 9; k++) begin
            read_port(lv[k].port, lv[k].vpn2, lv[k].odd, lv[k].asid, af, ai, ap);
            chk($sformatf("tbl_found_%0d", k), af, 32'(lv[k].found));
            chk($sformatf("tbl_index_%0d", k), ai, 32'(lv[k].index));
            chk($sformatf("tbl_page_%0d", k), ap, 32'({lv[k].pfn, lv[k].c, lv[k].d, lv[k].v}));
        end

        for (int k = 0; k < 4; k++) begin
            do_op(2'b01, 4'd0, pv[k].hi, 32'd0, 32'd0);
            chk($sformatf("tbl_probe_found_%0d", k), p_found, pv[k].found);
            chk($sformatf("tbl_probe_index_%0d", k), p_index, pv[k].index);
        end

        // TLBR with op_valid held through RESP: second accept only two cycles later.
        @(negedge clk);
        op_code = 2'b10; c0_index = 32'd3; op_valid = 1'b1;
        @(posedge clk);
        model_accept(2'b10, 4'd3, 32'd0, 32'd0, 32'd0);
        #1;
        chk("hold_tlbr_op_1", tlbr_op, 1);
        chk("hold_r_vpn2", r_vpn2, 19'h12345);
        chk("hold_r_asid", r_asid, 8'h05);
        chk("hold_r_pfn1", r_pfn1, 20'h81);
        chk("hold_r_v1", r_v1, 1);
        chk("hold_r_g", r_g, 0);
        @(posedge clk); #1;
        chk("hold_gap_done", op_done, 0);
        chk("hold_gap_ready", op_ready, 1);
        @(posedge clk);
        model_accept(2'b10, 4'd3, 32'd0, 32'd0, 32'd0);
        #1;
        chk("hold_tlbr_op_2", tlbr_op, 1);
        op_valid = 1'b0;
        @(posedge clk); #1;
        chk("hold_end_done", op_done, 0);

        do_op(2'b10, 4'd7, 32'd0, 32'd0, 32'd0);
        chk("tlbr7_r_g", r_g, 1);

        @(negedge clk);
        op_code = 2'b00; op_valid = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("reserved_done", op_done, 0);
            chk("reserved_ready", op_ready, 1);
        end
        op_valid = 1'b0;

        do_op(2'b11, 4'd12, 32'hAAAAA011, 32'h00000003, 32'h00000001);
        do_op(2'b01, 4'd0, 32'hAAAAA011, 32'd0, 32'd0);
        chk("wi_then_p_index", p_index, 12);

        for (int n = 0; n < 250; n++) begin
            logic [1:0]  code;
            logic [18:0] vp;
            logic [31:0] lo0, lo1;
            code = 2'($urandom_range(1, 3));
            vp   = ($urandom_range(0, 5) == 5) ? 19'($urandom) : pool[$urandom_range(0, 4)];
            lo0  = $urandom;
            lo1  = $urandom;
            if ($urandom_range(0, 2) == 0) begin lo0[0] = 1'b1; lo1[0] = 1'b1; end
            do_op(code, 4'($urandom_range(0, 15)), {vp, 5'($urandom), 8'($urandom_range(0, 3))}, lo0, lo1);
            chk_look(0, pool[$urandom_range(0, 4)], 1'($urandom), 8'($urandom_range(0, 3)));
            chk_look(1, pool[$urandom_range(0, 4)], 1'($urandom), 8'($urandom_range(0, 3)));
        end

        // Reset asserted while a TLBP result is being presented.
        @(negedge clk);
        op_code = 2'b01; c0_entryhi = 32'h2468A005; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("rstresp_tlbp_op", tlbp_op, 1);
        resetn = 1'b0;
        #1;
        model_clear();
        chk("rstresp_pulses", {tlbp_op, tlbr_op, op_done}, 0);
        chk_results();
        @(negedge clk) resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rstresp_no_pulse", {tlbp_op, op_done}, 0);
        end
        chk_look(0, 19'h12345, 1'b0, 8'h05);
        read_port(0, 19'h0, 1'b0, 8'h0, af, ai, ap);
        chk("rstresp_zero_hit", af, 1);
        chk("rstresp_zero_index", ai, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tlb_unit.md
Name: tlb_unit

Overview:
- 16-entry MIPS32-style joint TLB.
- Provides two combinational lookup ports: s0 for fetch and s1 for load/store.
- Provides a sequenced TLBP/TLBR/TLBWI operation engine with a valid/ready request handshake.
- Acts as the responder side of CP0's TLB interface. It consumes EntryHi/EntryLo0/EntryLo1/Index and returns the one-cycle tlbp_op/tlbr_op pulses plus the probe/read fields that CP0 latches.

Parameters:
- TLBNUM, 16, number of entries. Fixed at 16; the index is 4 bits.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s0_vpn2  in  19  fetch lookup VPN2 (va[31:13])
- s0_odd_page  in  1  va[12]; selects the odd half of the entry
- s0_asid  in  8  current ASID
- s0_found  out  1  match found
- s0_index  out  4  lowest matching index
- s0_pfn  out  20  PFN of the selected half
- s0_c  out  3  cache attribute of the selected half
- s0_d  out  1  dirty bit of the selected half
- s0_v  out  1  valid bit of the selected half
- s1_vpn2, s1_odd_page, s1_asid, s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v  same widths/meanings as s0  data lookup port
- op_valid  in  1  TLB instruction request
- op_code  in  2  01=TLBP, 10=TLBR, 11=TLBWI, 00=reserved
- op_ready  out  1  engine idle, can accept a request
- c0_entryhi  in  32  {vpn2[31:13], 0, asid[7:0]}
- c0_entrylo0  in  32  {0, pfn[25:6], c[5:3], d[2], v[1], g[0]}
- c0_entrylo1  in  32  same layout as c0_entrylo0
- c0_index  in  32  index in [3:0]
- tlbp_op  out  1  one-cycle probe-result pulse
- p_found  out  1  probe hit
- p_index  out  4  probe index
- tlbr_op  out  1  one-cycle read-result pulse
- r_vpn2  out  19  read VPN2
- r_asid  out  8  read ASID
- r_g  out  1  read global bit
- r_pfn0, r_c0, r_d0, r_v0  out  20/3/1/1  read even-page fields
- r_pfn1, r_c1, r_d1, r_v1  out  20/3/1/1  read odd-page fields
- op_done  out  1  one-cycle completion pulse, any op

Behaviour:
- Entry contents: vpn2[18:0], asid[7:0], g, and {pfn, c, d, v} for each of the even (0) and odd (1) halves.
- Reset (resetn low, asynchronous):
  - All entry fields cleared to 0.
  - FSM goes to IDLE.
  - All outputs except the combinational lookup results reset to 0.
  - Lookup results reflect the cleared array; e.g. vpn2=0, asid=0 hits index 0.
- Match rule: entry i matches when vpn2 equal AND (g OR asid equal).
- Multiple matches: lowest index wins.
- No match: found=0, index=0, pfn/c/d/v=0.
- Lookup ports are purely combinational; no latency.
- A TLBWI performed at edge N is visible to lookups from cycle N+1.
- FSM states: IDLE, RESP.
- IDLE:
  - op_ready=1.
  - Accept on op_valid && op_code!=00 and go to RESP.
  - op_code=00 is ignored: no state change, no pulse.
- At the accept edge:
  - TLBP: compare c0_entryhi.vpn2/asid against all entries (same match and priority rule). Register p_found and p_index; p_index=0 on miss.
  - TLBR: register entry[c0_index[3:0]] into the r_* outputs. r_g is written from entry g.
  - TLBWI: write entry[c0_index[3:0]]:
    - vpn2 ← entryhi[31:13], asid ← entryhi[7:0]
    - g ← entrylo0[0] & entrylo1[0]
    - pfn0/c0/d0/v0 ← entrylo0 fields; pfn1/c1/d1/v1 ← entrylo1 fields
- RESP:
  - op_ready=0; op_done=1 for exactly this cycle.
  - tlbp_op=1 only if the op was TLBP; tlbr_op=1 only if the op was TLBR.
  - Returns to IDLE unconditionally.
- Latency: request accepted at cycle N gives result pulses at cycle N+1. Next accept possible at N+2.
- p_* and r_* hold their last values between pulses; they change only at accept edges of their own op type.
- op_valid while in RESP is not accepted; the requester holds it until op_ready.
- TLBP immediately after a TLBWI to a matching VPN sees the newly written entry.
- Reset asserted during RESP: no pulse is emitted afterwards; an in-flight TLBWI whose accept edge already passed is lost, because reset clears the array.

Test Plan:
- Reset, then search s0 with vpn2=0x12345, asid=5 → s0_found=0; op_ready=1; tlbp_op, tlbr_op and op_done all 0.
- TLBWI, index=3, entryhi=0x2468A005, lo0=0x00001237, lo1=0x0000204E → op_done pulse at N+1 only. Then s1 vpn2=0x12345, odd=1, asid=5 → found=1, index=3, pfn=0x81, c=1, d=1, v=1. Note lo0 g=1 and lo1 g=0, so g=0.
- TLBWI with g=1 in both lo0 and lo1, index=7, vpn2=0x00ABC, asid=9 → s0 lookup with asid=2 hits, index=7.
- Same vpn2 written to indices 2 and 9, then TLBP → tlbp_op pulse with p_found=1, p_index=2. TLBP with an unmatched vpn2 → p_found=0, p_index=0.
- TLBR, index=3 after the second scenario → tlbr_op pulse with r_vpn2=0x12345, r_asid=5, r_pfn1=0x81, r_v1=1, r_g=0. op_valid held during RESP → accepted only at N+2.
- resetn pulsed low during RESP of a TLBP → outputs go to 0 immediately; no tlbp_op afterwards; s0 lookups show the cleared array.
